axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 226 ++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite master fronted by a command/response handshake
// Optional feature: define AXIL_CMD_MASTER_ERRCNT_EN to build the saturating err_count counter.
module axil_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  // command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  // AXI write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // AXI write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // AXI write response channel
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // AXI read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  // status
  output logic [7:0]                      err_count
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // registered command payload; AXI payload outputs come straight from here so
  // they cannot move while a VALID is up
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic                          write_q;

  // AW and W complete independently, so each keeps its own pending flag
  logic aw_pend;
  logic w_pend;

  logic cmd_acc;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;

  assign cmd_acc = cmd_valid && cmd_ready;
  assign aw_hs   = aw_pend && M_AXI_AWREADY;
  assign w_hs    = w_pend && M_AXI_WREADY;
  assign b_hs    = (state == WRESP) && M_AXI_BVALID;
  assign r_hs    = (state == RDATA) && M_AXI_RVALID;

  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWVALID = aw_pend;
  assign M_AXI_WVALID  = w_pend;

  // state register
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and state-decoded handshake outputs
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        // leave only when both channels are done, counting a handshake this cycle
        if ((!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY)) begin
          state_nxt = WRESP;
        end
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          state_nxt = RESP;
        end
      end
      READ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_nxt = RDATA;
        end
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // capture the command payload on accept
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
    end else if (cmd_acc) begin
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
      write_q <= cmd_write;
    end
  end

  // AW/W valid flags: raised together on a write accept, each dropped after its own handshake
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (cmd_acc && cmd_write) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_pend <= 1'b0;
      end
      if (w_hs) begin
        w_pend <= 1'b0;
      end
    end
  end

  // response registers; a write response leaves rsp_rdata at its previous value
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else if (b_hs) begin
      rsp_write <= write_q;
      rsp_resp  <= M_AXI_BRESP;
    end else if (r_hs) begin
      rsp_write <= write_q;
      rsp_rdata <= M_AXI_RDATA;
      rsp_resp  <= M_AXI_RRESP;
    end
  end

`ifdef AXIL_CMD_MASTER_ERRCNT_EN
  logic [7:0] err_q;
  logic       cap;
  logic [1:0] cap_resp;

  assign cap       = b_hs || r_hs;
  assign cap_resp  = b_hs ? M_AXI_BRESP : M_AXI_RRESP;
  assign err_count = err_q;

  // count non-OKAY responses, sticking at all-ones
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      err_q <= 8'h00;
    end else if (cap && (cap_resp != 2'b00) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed self-checking bench for axil_cmd_master with a 4-register AXI-Lite slave
module tb_axil_cmd_master;

`ifdef AXIL_CMD_MASTER_ERRCNT_EN
  localparam logic [31:0] EXP_ERR = 32'd2;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  axil_cmd_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave knobs and observation counters
  int         aw_dly = 0;
  int         w_dly  = 0;
  logic [1:0] rresp_force = 2'b00;
  int         aw_hs_n = 0;
  int         w_hs_n  = 0;
  int         b_phase_n = 0;

  logic [31:0] mem [4];
  logic        aw_got, w_got, ar_got, bready_q;
  int          aw_wait, w_wait;
  logic [15:0] aw_addr_q, ar_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  // 4-register AXI-Lite slave with programmable AWREADY/WREADY delays
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; bready_q <= 1'b0;
      aw_wait <= 0; w_wait <= 0;
    end else begin
      bready_q <= bready;
      if (bready && !bready_q) b_phase_n <= b_phase_n + 1;
      if (awvalid && awready) begin
        awready <= 1'b0; aw_got <= 1'b1; aw_addr_q <= awaddr; aw_wait <= 0; aw_hs_n <= aw_hs_n + 1;
      end else if (awvalid && !aw_got && !awready) begin
        if (aw_wait >= aw_dly) awready <= 1'b1; else aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
        wready <= 1'b0; w_got <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_wait <= 0; w_hs_n <= w_hs_n + 1;
      end else if (wvalid && !w_got && !wready) begin
        if (w_wait >= w_dly) wready <= 1'b1; else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        for (int i = 0; i < 4; i++)
          if (w_strb_q[i]) mem[aw_addr_q[3:2]][8*i +: 8] <= w_data_q[8*i +: 8];
        bvalid <= 1'b1; bresp <= 2'b00; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        arready <= 1'b0; ar_got <= 1'b1; ar_addr_q <= araddr;
      end else if (arvalid && !ar_got && !arready) begin
        arready <= 1'b1;
      end
      if (ar_got && !rvalid) begin
        rvalid <= 1'b1; rdata <= mem[ar_addr_q[3:2]]; rresp <= rresp_force; ar_got <= 1'b0;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // present a command, wait for cmd_ready, return in the cycle after acceptance
  task automatic issue(input string tag, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      tick(1);
      n++;
    end
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick(1);
      n++;
    end
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check({tag, "_idle_after"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  int aw0, w0, b0;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    tick(3);
    check("rst_handshakes", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_payload", {awaddr, 12'd0, wstrb}, 32'h0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // basic write then read-back
    issue("wr4", 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    check("wr4_aw_w_valid", {30'd0, awvalid, wvalid}, 32'd3);
    check("wr4_awaddr", {16'd0, awaddr}, 32'h0004);
    check("wr4_wdata", wdata, 32'hDEADBEEF);
    check("wr4_wstrb_prot", {25'd0, awprot, wstrb}, 32'h0000000F);
    check("wr4_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    wait_rsp("wr4");
    check("wr4_rsp", {29'd0, rsp_write, rsp_resp}, 32'h4);
    consume("wr4");
    issue("rd4", 1'b0, 16'h0004, 32'h0, 4'h0);
    check("rd4_arvalid", {31'd0, arvalid}, 32'd1);
    check("rd4_araddr_prot", {13'd0, arprot, araddr}, 32'h0004);
    wait_rsp("rd4");
    check("rd4_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd4_rsp", {29'd0, rsp_write, rsp_resp}, 32'h0);
    consume("rd4");

    // byte strobes
    issue("wr8a", 1'b1, 16'h0008, 32'hFFFFFFFF, 4'hF);
    wait_rsp("wr8a");
    consume("wr8a");
    issue("wr8b", 1'b1, 16'h0008, 32'h11223344, 4'b0101);
    wait_rsp("wr8b");
    check("wr8b_rdata_held", rsp_rdata, 32'hDEADBEEF);
    consume("wr8b");
    issue("rd8", 1'b0, 16'h0008, 32'h0, 4'h0);
    wait_rsp("rd8");
    check("rd8_rdata", rsp_rdata, 32'hFF22FF44);
    consume("rd8");

    // AWREADY three cycles ahead of WREADY
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_phase_n;
    aw_dly = 0; w_dly = 3;
    issue("wrc", 1'b1, 16'h000C, 32'h12345678, 4'hF);
    tick(2);
    check("wrc_aw_done_w_pending", {30'd0, awvalid, wvalid}, 32'd1);
    wait_rsp("wrc");
    check("wrc_hs_counts", {aw_hs_n - aw0, w_hs_n - w0, b_phase_n - b0} == {32'd1, 32'd1, 32'd1}, 32'd1);
    consume("wrc");

    // AWREADY and WREADY in the same cycle
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_phase_n;
    aw_dly = 2; w_dly = 2;
    issue("wr0", 1'b1, 16'h0000, 32'hCAFEF00D, 4'hF);
    tick(2);
    check("wr0_both_pending", {30'd0, awvalid, wvalid}, 32'd3);
    wait_rsp("wr0");
    check("wr0_hs_counts", {aw_hs_n - aw0, w_hs_n - w0, b_phase_n - b0} == {32'd1, 32'd1, 32'd1}, 32'd1);
    consume("wr0");
    aw_dly = 0; w_dly = 0;

    // response held back for five cycles
    issue("rdc", 1'b0, 16'h000C, 32'h0, 4'h0);
    wait_rsp("rdc");
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rdc_hold_valid_ready", {30'd0, rsp_valid, cmd_ready}, 32'd2);
      check("rdc_hold_rdata", rsp_rdata, 32'h12345678);
    end
    consume("rdc");

    // two SLVERR reads
    rresp_force = 2'b10;
    issue("err1", 1'b0, 16'h0000, 32'h0, 4'h0);
    wait_rsp("err1");
    check("err1_resp", {30'd0, rsp_resp}, 32'd2);
    check("err1_rdata", rsp_rdata, 32'hCAFEF00D);
    consume("err1");
    issue("err2", 1'b0, 16'h0004, 32'h0, 4'h0);
    wait_rsp("err2");
    check("err2_resp", {30'd0, rsp_resp}, 32'd2);
    consume("err2");
    check("err_count", {24'd0, err_count}, EXP_ERR);
    rresp_force = 2'b00;

    // reset in the middle of a write with W still outstanding
    w_dly = 40;
    issue("wrx", 1'b1, 16'h0004, 32'h0BADBEEF, 4'hF);
    tick(3);
    check("wrx_w_pending", {30'd0, awvalid, wvalid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("wrx_async_drop", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
    check("wrx_async_wdata", wdata, 32'h0);
    check("wrx_async_err", {24'd0, err_count}, 32'd0);
    tick(2);
    w_dly = 0;
    rst_n = 1'b1;
    tick(1);
    check("wrx_release", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    issue("rdx", 1'b0, 16'h000C, 32'h0, 4'h0);
    wait_rsp("rdx");
    check("rdx_rdata", rsp_rdata, 32'h12345678);
    consume("rdx");
    issue("rdy", 1'b0, 16'h0004, 32'h0, 4'h0);
    wait_rsp("rdy");
    check("rdy_rdata_unchanged", rsp_rdata, 32'hDEADBEEF);
    consume("rdy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
